// File: rtl/demux2_buf_if.sv
// Handshake bundle for the two-channel buffered demultiplexer.
// The slave modport belongs to the demux; the master modport is the surrounding logic.
interface demux2_buf_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic [1:0]       out0_count;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [1:0]       out1_count;

  modport slave (
    input  in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready,
    output out0_valid, out0_data, out0_count,
    output out1_valid, out1_data, out1_count
  );

  modport master (
    output in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready,
    input  out0_valid, out0_data, out0_count,
    input  out1_valid, out1_data, out1_count
  );
endinterface

// File: rtl/demux2_buf.sv
// Routes one upstream stream into two independent 2-entry FIFOs chosen by in_sel.
// Outputs come straight from registered head slots; in_ready never looks at the consumers.
module demux2_buf #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  demux2_buf_if.slave  bus
);

  logic [1:0]       out_ready;
  logic [1:0]       sel_onehot;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       count_w [2];
  logic [WIDTH-1:0] head_w  [2];

  assign out_ready  = {bus.out1_ready, bus.out0_ready};
  assign sel_onehot = {bus.in_sel, ~bus.in_sel};

  // A full FIFO refuses input even when it is being drained this cycle.
  assign bus.in_ready = (count_w[bus.in_sel] != 2'd2);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_ch
      logic [1:0]       count_q, count_d;
      logic [WIDTH-1:0] head_q, head_d;
      logic [WIDTH-1:0] tail_q, tail_d;

      assign push[gi] = bus.in_valid & bus.in_ready & sel_onehot[gi];
      assign pop[gi]  = (count_q != 2'd0) & out_ready[gi];

      always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case ({push[gi], pop[gi]})
          2'b10: begin
            if (count_q == 2'd0) head_d = bus.in_data;
            else                 tail_d = bus.in_data;
            count_d = count_q + 2'd1;
          end
          2'b01: begin
            if (count_q == 2'd2) head_d = tail_q;
            count_d = count_q - 2'd1;
          end
          // Push and pop together only happen at count 1: the new word replaces the head.
          2'b11: head_d = bus.in_data;
          default: ;
        endcase
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count_q <= 2'd0;
          head_q  <= '0;
          tail_q  <= '0;
        end else begin
          count_q <= count_d;
          head_q  <= head_d;
          tail_q  <= tail_d;
        end
      end

      assign count_w[gi] = count_q;
      assign head_w[gi]  = head_q;
    end
  endgenerate

  assign bus.out0_valid = (count_w[0] != 2'd0);
  assign bus.out0_data  = head_w[0];
  assign bus.out0_count = count_w[0];
  assign bus.out1_valid = (count_w[1] != 2'd0);
  assign bus.out1_data  = head_w[1];
  assign bus.out1_count = count_w[1];

endmodule

// File: tb/tb_demux2_buf.sv
// Scenario bench for demux2_buf: directed corner cases plus a random stream
// checked against per-channel queues.
module tb_demux2_buf;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  demux2_buf_if #(.WIDTH(8)) bus ();

  demux2_buf #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = 8'h00;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
  endtask

  // Pulse reset between edges; called just after an edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic push_word(input logic sel, input logic [7:0] data);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out0_count !== 2'd0 || bus.out1_count !== 2'd0 || bus.out0_valid !== 1'b0 ||
        bus.out1_valid !== 1'b0 || bus.out0_data !== 8'h00 || bus.out1_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: cnt0=%0d cnt1=%0d v0=%b v1=%b d0=%h d1=%h, required all zero",
               bus.out0_count, bus.out1_count, bus.out0_valid, bus.out1_valid,
               bus.out0_data, bus.out1_data);
    end
    cyc();
    reset_n = 1'b1;
    cyc();
    $display("test_reset: done");
  endtask

  task automatic test_basic_push();
    do_reset();
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 8'hA5; bus.out0_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_in_ready: got %b, required 1", bus.in_ready);
    end
    cyc();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'hA5 || bus.out0_count !== 2'd1 ||
        bus.out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_push: v0=%b d0=%h cnt0=%0d v1=%b, required 1 a5 1 0",
               bus.out0_valid, bus.out0_data, bus.out0_count, bus.out1_valid);
    end
    $display("test_basic_push: out0_data=%h", bus.out0_data);
  endtask

  task automatic test_fill_ch1();
    do_reset();
    idle_inputs();
    push_word(1'b1, 8'h11);
    push_word(1'b1, 8'h22);
    bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 8'h33;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_ch1_ready: got %b, required 0", bus.in_ready);
    end
    cyc();
    n_checks++;
    if (bus.out1_count !== 2'd2 || bus.out1_data !== 8'h11 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ch1_state: cnt1=%0d d1=%h rdy=%b, required 2 11 0",
               bus.out1_count, bus.out1_data, bus.in_ready);
    end
    bus.in_sel = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL sel0_ready: got %b, required 1", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    bus.out1_ready = 1'b1;
    cyc();
    n_checks++;
    if (bus.out1_data !== 8'h22 || bus.out1_count !== 2'd1) begin
      n_fail++; $display("FAIL ch1_second: d1=%h cnt1=%0d, required 22 1", bus.out1_data, bus.out1_count);
    end
    bus.out1_ready = 1'b0;
    $display("test_fill_ch1: done");
  endtask

  task automatic test_push_pop_same();
    do_reset();
    idle_inputs();
    push_word(1'b0, 8'h01);
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 8'h02; bus.out0_ready = 1'b1;
    cyc();
    idle_inputs();
    n_checks++;
    if (bus.out0_count !== 2'd1 || bus.out0_data !== 8'h02) begin
      n_fail++;
      $display("FAIL push_pop_cnt1: cnt0=%0d d0=%h, required 1 02", bus.out0_count, bus.out0_data);
    end
    $display("test_push_pop_same: out0_data=%h", bus.out0_data);
  endtask

  task automatic test_full_blocks();
    do_reset();
    idle_inputs();
    push_word(1'b0, 8'h10);
    push_word(1'b0, 8'h20);
    bus.out0_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 8'h30;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_ready: got %b, required 0", bus.in_ready);
    end
    cyc();
    n_checks++;
    if (bus.out0_count !== 2'd1 || bus.out0_data !== 8'h20 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_after: cnt0=%0d d0=%h rdy=%b, required 1 20 1",
               bus.out0_count, bus.out0_data, bus.in_ready);
    end
    cyc();
    idle_inputs();
    n_checks++;
    if (bus.out0_count !== 2'd1 || bus.out0_data !== 8'h30) begin
      n_fail++;
      $display("FAIL full_retry: cnt0=%0d d0=%h, required 1 30", bus.out0_count, bus.out0_data);
    end
    cyc();
    n_checks++;
    if (bus.out0_data !== 8'h30 || bus.out0_valid !== 1'b1) begin
      n_fail++; $display("FAIL hold_stable: d0=%h v0=%b, required 30 1", bus.out0_data, bus.out0_valid);
    end
    $display("test_full_blocks: done");
  endtask

  task automatic test_async_reset();
    realtime t0;
    do_reset();
    idle_inputs();
    push_word(1'b0, 8'hC1);
    push_word(1'b0, 8'hC2);
    push_word(1'b1, 8'hD1);
    push_word(1'b1, 8'hD2);
    n_checks++;
    if (bus.out0_count !== 2'd2 || bus.out1_count !== 2'd2) begin
      n_fail++; $display("FAIL both_full: cnt0=%0d cnt1=%0d, required 2 2", bus.out0_count, bus.out1_count);
    end
    #2;
    t0 = $realtime;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out0_count !== 2'd0 || bus.out1_count !== 2'd0 || bus.out0_valid !== 1'b0 ||
        bus.out1_valid !== 1'b0 || bus.out0_data !== 8'h00 || bus.out1_data !== 8'h00 ||
        ($realtime - t0) > 2.0) begin
      n_fail++;
      $display("FAIL async_reset: cnt0=%0d cnt1=%0d v0=%b v1=%b, required 0 0 0 0",
               bus.out0_count, bus.out1_count, bus.out0_valid, bus.out1_valid);
    end
    reset_n = 1'b1;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
        n_fail++; $display("FAIL stale_data: v0=%b v1=%b, required 0 0", bus.out0_valid, bus.out1_valid);
      end
    end
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    push_word(1'b1, 8'h5A);
    n_checks++;
    if (bus.out1_valid !== 1'b1 || bus.out1_data !== 8'h5A || bus.out1_count !== 2'd1) begin
      n_fail++;
      $display("FAIL first_push_after_reset: v1=%b d1=%h cnt1=%0d, required 1 5a 1",
               bus.out1_valid, bus.out1_data, bus.out1_count);
    end
    $display("test_async_reset: done");
  endtask

  task automatic test_random_stream();
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int acc = 0;
    int cycles = 0;
    int fails_before = n_fail;
    logic exp_rdy;
    do_reset();
    idle_inputs();
    while ((acc < 1000 || q0.size() != 0 || q1.size() != 0) && cycles < 20000) begin
      bus.in_valid   = (acc < 1000) && ($urandom_range(0, 3) != 0);
      bus.in_sel     = 1'($urandom_range(0, 1));
      bus.in_data    = 8'($urandom);
      bus.out0_ready = 1'($urandom_range(0, 1));
      bus.out1_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = bus.in_sel ? (q1.size() < 2) : (q0.size() < 2);
      n_checks++;
      if (bus.in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rand_in_ready cyc %0d: got %b, required %b", cycles, bus.in_ready, exp_rdy);
      end
      n_checks++;
      if (bus.out0_valid !== (q0.size() != 0) || (q0.size() != 0 && bus.out0_data !== q0[0])) begin
        n_fail++;
        $display("FAIL rand_out0 cyc %0d: v0=%b d0=%h, required %b %h", cycles, bus.out0_valid,
                 bus.out0_data, q0.size() != 0, (q0.size() != 0) ? q0[0] : 8'h00);
      end
      n_checks++;
      if (bus.out1_valid !== (q1.size() != 0) || (q1.size() != 0 && bus.out1_data !== q1[0])) begin
        n_fail++;
        $display("FAIL rand_out1 cyc %0d: v1=%b d1=%h, required %b %h", cycles, bus.out1_valid,
                 bus.out1_data, q1.size() != 0, (q1.size() != 0) ? q1[0] : 8'h00);
      end
      if (q0.size() != 0 && bus.out0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && bus.out1_ready) void'(q1.pop_front());
      if (bus.in_valid && exp_rdy) begin
        if (bus.in_sel) q1.push_back(bus.in_data);
        else            q0.push_back(bus.in_data);
        acc++;
      end
      cyc();
      cycles++;
      n_checks++;
      if (bus.out0_count !== 2'(q0.size()) || bus.out1_count !== 2'(q1.size()) ||
          bus.out0_count > 2'd2 || bus.out1_count > 2'd2) begin
        n_fail++;
        $display("FAIL rand_count cyc %0d: cnt0=%0d cnt1=%0d, required %0d %0d",
                 cycles, bus.out0_count, bus.out1_count, q0.size(), q1.size());
      end
    end
    n_checks++;
    if (cycles >= 20000) begin
      n_fail++; $display("FAIL rand_timeout: accepted %0d, required 1000", acc);
    end
    idle_inputs();
    $display("test_random_stream: %0d words in %0d cycles, %0d new failures",
             acc, cycles, n_fail - fails_before);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_push();
    test_fill_ch1();
    test_push_pop_same();
    test_full_blocks();
    test_async_reset();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux2_buf.md
DEMUX2_BUF -- requirements
Module: demux2_buf

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the block accepts the upstream word this cycle.
REQ-006 The module SHALL have port in_sel, input, 1 bit: the destination channel (0 or 1), qualified by in_valid.
REQ-007 The module SHALL have port in_data, input, WIDTH bits: the upstream word.
REQ-008 The module SHALL have ports outN_valid, output, 1 bit, for N=0,1: channel N has a word.
REQ-009 The module SHALL have ports outN_ready, input, 1 bit, for N=0,1: the channel N consumer takes its word.
REQ-010 The module SHALL have ports outN_data, output, WIDTH bits, for N=0,1: the channel N head word.
REQ-011 The module SHALL have ports outN_count, output, 2 bits, for N=0,1: the occupancy of channel N, 0..2.

Function
REQ-012 Each channel SHALL hold a 2-entry FIFO (head and tail slots) plus an occupancy counter.
REQ-013 A transfer in SHALL occur when in_valid and in_ready are both 1 at a rising edge, and the word SHALL be pushed to the FIFO selected by in_sel.
REQ-014 in_ready SHALL be 1 when the FIFO selected by in_sel has outN_count < 2, and 0 otherwise.
REQ-015 in_ready SHALL depend only on in_sel and registered state, never on outN_ready.
REQ-016 A push into a full FIFO SHALL never occur: a full FIFO blocks input even if it pops in the same cycle.
REQ-017 A transfer out on channel N SHALL occur when outN_valid and outN_ready are both 1 at a rising edge, and the head word SHALL be removed.
REQ-018 outN_valid SHALL equal (outN_count != 0), and outN_data SHALL be the registered head slot.
REQ-019 outN_data SHALL be held stable while outN_valid=1 and outN_ready=0.
REQ-020 Latency SHALL be exactly 1 cycle: a word accepted at edge k SHALL appear with outN_valid=1 after edge k if that FIFO was empty.
REQ-021 Each channel SHALL be first-in first-out: words appear in acceptance order.
REQ-022 A simultaneous push and pop on the same channel with count=1 SHALL leave count=1 and load the new word into the head slot.
REQ-023 Pops on the two channels SHALL be independent; both may pop in the same cycle as one push.
REQ-024 Counter updates SHALL be count+1 on push-only, count-1 on pop-only, and unchanged on push+pop or idle; count SHALL never exceed 2 or wrap below 0.
REQ-025 The unselected channel SHALL be unaffected by in_valid/in_data.
REQ-026 When in_valid=0, in_ready SHALL still reflect the occupancy of the in_sel channel.

Reset
REQ-027 Asserting reset_n=0 SHALL immediately, without a clock, force both counts to 0, outN_valid=0, and outN_data to 0.
REQ-028 A reset asserted mid-operation SHALL discard all buffered words; no word accepted before reset SHALL appear after it.
REQ-029 After deassertion, the first push SHALL be accepted on the first rising edge with reset_n=1 and in_valid=1.

Verification
REQ-030 The bench SHALL cover: reset, then push 0xA5 with sel=0 and out0_ready=0 -> after 1 edge out0_valid=1, out0_data=0xA5, out0_count=1, out1_valid=0.
REQ-031 The bench SHALL cover: push 0x11, 0x22, 0x33 to channel 1 with out1_ready=0 -> the first two are accepted, out1_count=2, and in_ready=0 while sel=1; setting sel=0 gives in_ready=1.
REQ-032 The bench SHALL cover: channel 0 at count=1 (0x01), push 0x02 with out0_ready=1 in the same cycle -> out0_count stays 1 and out0_data=0x02 next cycle.
REQ-033 The bench SHALL cover: a full channel 0 with out0_ready=1 and a sel=0 push offered -> the push is rejected that cycle (in_ready=0), count becomes 1, and the push is accepted next cycle.
REQ-034 The bench SHALL cover: both channels full, then reset_n pulsed low between edges -> counts become 0 and valids become 0 without a clock; after release, no old data appears.
REQ-035 The bench SHALL cover: a random 1000-word stream with random sel and ready -> per-channel output order matches a scoreboard and counts are never greater than 2.
